// File: rtl/req_drain_8b.sv
// Purpose: collect request events into an 8-bit pending set and drain them one per grant, bit 7 highest priority.
// Latency: set sampled at edge k -> pend_o after edge k -> out_valid_o after edge k+1 when idle; 1 grant/cycle sustained.
// Backpressure: a grant is held stable while out_ready_i=0; pending bits accumulate meanwhile (one level per bit).
// Optional feature: define REQ_DRAIN_8B_DROP_CNT_EN to add drop_cnt_o, a saturating count of requests merged into already-pending bits.
module req_drain_8b #(
    parameter logic [7:0] MASK_RST = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       set_valid_i,
    input  logic [2:0] set_idx_i,
    input  logic [7:0] set_vec_i,
    input  logic       mask_we_i,
    input  logic [7:0] mask_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_onehot_o,
    output logic [2:0] out_idx_o,
    output logic [7:0] pend_o
`ifdef REQ_DRAIN_8B_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] onehot_q, onehot_d;
    logic [2:0] idx_q, idx_d;

    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [7:0] elig;
    logic [7:0] pick_oh;
    logic [2:0] pick_idx;

    // Incoming requests: decoded single index merged with the bulk vector.
    always_comb begin
        set_bits = set_vec_i;
        if (set_valid_i) begin
            set_bits = set_bits | (8'd1 << set_idx_i);
        end
    end

    // Priority pick over registered pend/mask only; ascending scan so the highest set bit wins.
    always_comb begin
        elig     = pend_q & mask_q;
        pick_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (elig[i]) begin
                pick_idx = i[2:0];
            end
        end
        pick_oh = (elig != 8'd0) ? (8'd1 << pick_idx) : 8'd0;
    end

    // Grant FSM: the picked bit is cleared from pend at load time, not at handshake.
    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        clr_bits = 8'd0;
        case (state_q)
            IDLE: begin
                if (elig != 8'd0) begin
                    onehot_d = pick_oh;
                    idx_d    = pick_idx;
                    clr_bits = pick_oh;
                    state_d  = HOLD;
                end else begin
                    onehot_d = 8'd0;
                    idx_d    = 3'd0;
                end
            end
            HOLD: begin
                if (out_ready_i) begin
                    if (elig != 8'd0) begin
                        onehot_d = pick_oh;
                        idx_d    = pick_idx;
                        clr_bits = pick_oh;
                    end else begin
                        onehot_d = 8'd0;
                        idx_d    = 3'd0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                onehot_d = 8'd0;
                idx_d    = 3'd0;
                state_d  = IDLE;
            end
        endcase
    end

    // Pending/mask next state: a same-cycle set beats the clear of the granted bit.
    always_comb begin
        pend_d = (pend_q & ~clr_bits) | set_bits;
        mask_d = mask_we_i ? mask_i : mask_q;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            pend_q   <= 8'd0;
            mask_q   <= MASK_RST;
            onehot_q <= 8'd0;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
        end
    end

    assign out_valid_o  = (state_q == HOLD);
    assign out_onehot_o = onehot_q;
    assign out_idx_o    = idx_q;
    assign pend_o       = pend_q;

`ifdef REQ_DRAIN_8B_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       drop_hit;

    // A request landing on a bit that stays pending is merged; count it, saturating at 0xFF.
    always_comb begin
        drop_hit   = ((set_bits & pend_q & ~clr_bits) != 8'd0);
        drop_cnt_d = drop_cnt_q;
        if (drop_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    // Without the counter, merged requests are simply absorbed into pend.
`endif

endmodule

// File: doc/req_drain_8b.md
Name: req_drain_8b

Overview:
- Companion to the 8-bit priority picker. It collects request events into an 8-bit pending set, then drains them one at a time in fixed priority order.
- Requests arrive as a binary index (decoded to one-hot internally) or as a bulk vector.
- Output is a registered valid/ready stream carrying the granted request as both one-hot and binary index.
- Used between event sources (e.g. per-CU done flags) and a single-issue consumer.

Parameters:
- MASK_RST, 8'hFF, reset value of the internal eligibility mask register.

Ports:
- clk_i  input  1  clock, all state on rising edge
- rst_n_i  input  1  asynchronous active-low reset
- set_valid_i  input  1  single-request strobe
- set_idx_i  input  3  index of single request; decoded to one-hot when set_valid_i=1
- set_vec_i  input  8  bulk request vector, ORed with the decoded index
- mask_we_i  input  1  write strobe for the eligibility mask
- mask_i  input  8  new mask value, loaded when mask_we_i=1
- out_valid_o  output  1  grant available
- out_ready_i  input  1  consumer accepts grant
- out_onehot_o  output  8  granted request, one-hot
- out_idx_o  output  3  granted request, binary index
- pend_o  output  8  current pending register (registered)
- drop_cnt_o  output  8  present only with REQ_DRAIN_8B_DROP_CNT_EN

Behaviour:
- Reset (async, rst_n_i=0): pend=0, mask=MASK_RST, state=IDLE, out_valid_o=0, out_onehot_o=0, out_idx_o=0, drop_cnt_o=0.
  - Asserting reset mid-operation discards any held grant and all pending bits immediately.
- set_bits = (set_valid_i ? 1<<set_idx_i : 0) | set_vec_i.
- pend_next = (pend & ~clr_bits) | set_bits.
  - A set in the same cycle as a clear of the same bit wins: the bit stays pending as a new request.
- Eligible vector: elig = pend & mask. Selection uses registered pend/mask only; same-cycle sets are not visible.
- Priority: bit 7 highest, bit 0 lowest. Pick = highest set bit of elig.
- Masked-out bits remain pending indefinitely and are never granted until unmasked.
- mask updates on the edge where mask_we_i=1 and takes effect for selections from the next cycle.
- FSM:
  - IDLE: if elig!=0, load the pick into out_onehot_o/out_idx_o, set clr_bits=pick, set out_valid_o=1, go HOLD. Otherwise stay IDLE with outputs held at 0.
  - HOLD: outputs stable while out_valid_o=1 and out_ready_i=0 (no change allowed).
    - On handshake (out_ready_i=1), if elig!=0, load the next pick in the same edge and stay HOLD, sustaining 1 grant/cycle.
    - On handshake with elig==0, clear out_valid_o and outputs to 0, go IDLE.
- The granted bit is cleared from pend when it is loaded into the output register, not on handshake. A re-set of that bit while it is held becomes a fresh pending request.
- Latency: set sampled at edge k -> pend_o shows it after edge k -> out_valid_o=1 after edge k+1 (idle case).
- Setting an already-pending bit has no effect on pend (no queuing depth >1 per bit).
- out_onehot_o is always 0 or one-hot. out_idx_o always matches out_onehot_o, and is 0 when not valid.

Optional Feature:
- Macro REQ_DRAIN_8B_DROP_CNT_EN.
- Defined: drop_cnt_o exists. It is an 8-bit counter incremented once per cycle in which (set_bits & pend & ~clr_bits) != 0, i.e. a request merged into an already-pending bit. It saturates at 8'hFF and is cleared only by reset.
- Undefined: the port and counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then set_valid_i=1, set_idx_i=5, out_ready_i=1 -> pend_o=8'h20 after edge 0; out_valid_o=1, out_onehot_o=8'h20, out_idx_o=5 after edge 1; back to IDLE, pend_o=0, after edge 2.
- set_vec_i=8'h91 one cycle, out_ready_i=1 -> grants 8'h80, 8'h10, 8'h01 on consecutive cycles, then out_valid_o=0.
- As above with out_ready_i=0 for 3 cycles -> 8'h80/idx 7 held stable for those cycles, then drain continues in order on release.
- mask_i=8'h0F written, then set_vec_i=8'hF1 -> only 8'h01 granted and pend_o=8'hF0 remains. Then mask_i=8'hFF -> 8'h80, 8'h40, 8'h20, 8'h10 granted.
- Bit 3 held in output (ready=0), set_idx_i=3 again -> pend_o=8'h08. After handshake, idx 3 is granted a second time. A set of idx 3 while pend bit 3 is already 1 -> drop_cnt_o=1 (macro on).
- set_vec_i=8'hFF, grant 8'h80 held, assert rst_n_i=0 asynchronously mid-cycle -> all outputs 0 immediately. After release, no grant until a new set.
